// File: rtl/riscv_pkg.sv
// Shared types for the load/store unit: access size, LSU state encoding and
// small decode helpers used by both the control and alignment logic.
package riscv_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ1,
    RESP1,
    REQ2,
    RESP2
  } lsu_state_e;

  // Lane mask of an access before it is shifted to its byte offset.
  // The reserved size encoding behaves like WORD.
  function automatic logic [3:0] size_mask(lsu_size_e size);
    case (size)
      BYTE:    return 4'b0001;
      HALF:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // An access is misaligned when it does not fit inside one 32-bit word.
  function automatic logic is_misaligned(lsu_size_e size, logic [1:0] off);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return (off == 2'd3);
      default: return (off != 2'd0);
    endcase
  endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
// Request phase: data_req held until data_gnt. Response phase: data_rvalid
// with data_rdata/data_err, no earlier than the cycle after data_gnt.
interface rv_lsu_if;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );
endinterface

// File: rtl/rv_lsu_align.sv
// Combinational lane alignment for the LSU: byte enables and store data
// shifted to the byte offset, load data shifted down and zero/sign extended.
// With RV_LSU_MISALIGN_EN the shift spans two words so an access crossing a
// word boundary yields a low-word and a high-word half.
module rv_lsu_align
  import riscv_pkg::*;
(
  input  lsu_size_e   size,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
`ifdef RV_LSU_MISALIGN_EN
  input  logic [31:0] rdata_hi,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_hi,
`endif
  output logic [3:0]  be_lo,
  output logic [31:0] wdata_lo,
  output logic [31:0] rdata_fmt
);

  logic [31:0] shifted;

`ifdef RV_LSU_MISALIGN_EN
  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;

  // two-word alignment: upper lanes of the first word, rest in the next word
  always_comb begin
    be_wide    = {4'b0000, size_mask(size)} << off;
    wdata_wide = {32'h0, wdata} << {off, 3'b000};
    shifted    = 32'({rdata_hi, rdata_lo} >> {off, 3'b000});
  end

  assign be_lo    = be_wide[3:0];
  assign be_hi    = be_wide[7:4];
  assign wdata_lo = wdata_wide[31:0];
  assign wdata_hi = wdata_wide[63:32];
`else
  // single-word alignment; misaligned accesses never reach the bus
  always_comb begin
    be_lo    = size_mask(size) << off;
    wdata_lo = wdata << {off, 3'b000};
    shifted  = rdata_lo >> {off, 3'b000};
  end
`endif

  // zero/sign extension by access size; WORD passes through untouched
  always_comb begin
    case (size)
      BYTE:    rdata_fmt = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      HALF:    rdata_fmt = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: rdata_fmt = shifted;
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// RISC-V load/store unit: accepts one request from execute, runs it on the
// data-memory bus and returns a one-cycle completion pulse with formatted
// load data. Optional macro RV_LSU_MISALIGN_EN splits misaligned accesses
// into two word transactions; without it they complete at once with an error.
//
// state | meaning
// IDLE  | ready for a request; completion pulse of the previous one may show
// REQ1  | data_req for the first (or only) word, waiting for data_gnt
// RESP1 | waiting for data_rvalid of the first word
// REQ2  | data_req for the second word of a split access
// RESP2 | waiting for data_rvalid of the second word
module rv_lsu
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_valid,
  input  logic        lsu_we,
  input  lsu_size_e   lsu_size,
  input  logic        lsu_sign_ext,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_req_ready,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        lsu_busy,
  rv_lsu_if.master    dmem
);

  lsu_state_e  state_q, state_d;
  logic        we_q, sx_q;
  lsu_size_e   size_q;
  logic [31:0] addr_q, wdata_q;
  logic        rvalid_q, err_q;
  logic [31:0] rdata_q;

  logic        accept, mis_in, req, done, done_err;
  logic [3:0]  be_lo;
  logic [31:0] wdata_lo, rdata_fmt, rdata_lo_sel;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;

`ifdef RV_LSU_MISALIGN_EN
  logic        mis_q, capture_lo;
  logic [31:0] buf_q;
  logic [3:0]  be_hi;
  logic [31:0] wdata_hi;
`endif

  assign lsu_req_ready = (state_q == IDLE);
  assign accept        = lsu_req_valid && lsu_req_ready;
  assign mis_in        = is_misaligned(lsu_size, lsu_addr[1:0]);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state, bus request and completion decode
  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    done     = 1'b0;
    done_err = 1'b0;
`ifdef RV_LSU_MISALIGN_EN
    capture_lo = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef RV_LSU_MISALIGN_EN
          state_d = REQ1;
`else
          if (mis_in) begin
            done     = 1'b1;
            done_err = 1'b1;
          end else begin
            state_d = REQ1;
          end
`endif
        end
      end
      REQ1: begin
        req = 1'b1;
        if (dmem.data_gnt) state_d = RESP1;
      end
      RESP1: begin
        if (dmem.data_rvalid) begin
          if (dmem.data_err) begin
            done     = 1'b1;
            done_err = 1'b1;
            state_d  = IDLE;
          end
`ifdef RV_LSU_MISALIGN_EN
          else if (mis_q) begin
            capture_lo = 1'b1;
            state_d    = REQ2;
          end
`endif
          else begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
`ifdef RV_LSU_MISALIGN_EN
      REQ2: begin
        req = 1'b1;
        if (dmem.data_gnt) state_d = RESP2;
      end
      RESP2: begin
        if (dmem.data_rvalid) begin
          done     = 1'b1;
          done_err = dmem.data_err;
          state_d  = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // request capture, split-load buffer and registered completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      sx_q     <= 1'b0;
      size_q   <= BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef RV_LSU_MISALIGN_EN
      mis_q    <= 1'b0;
      buf_q    <= '0;
`endif
    end else begin
      rvalid_q <= done;
      err_q    <= done_err;
      if (done) rdata_q <= (done_err || we_q) ? 32'h0 : rdata_fmt;
      if (accept) begin
        we_q    <= lsu_we;
        sx_q    <= lsu_sign_ext;
        size_q  <= lsu_size;
        addr_q  <= lsu_addr;
        wdata_q <= lsu_wdata;
`ifdef RV_LSU_MISALIGN_EN
        mis_q   <= mis_in;
`endif
      end
`ifdef RV_LSU_MISALIGN_EN
      if (capture_lo) buf_q <= dmem.data_rdata;
`endif
    end
  end

`ifdef RV_LSU_MISALIGN_EN
  assign rdata_lo_sel = (state_q == RESP2) ? buf_q : dmem.data_rdata;
`else
  assign rdata_lo_sel = dmem.data_rdata;
`endif

  rv_lsu_align u_align (
    .size      (size_q),
    .off       (addr_q[1:0]),
    .sign_ext  (sx_q),
    .wdata     (wdata_q),
    .rdata_lo  (rdata_lo_sel),
`ifdef RV_LSU_MISALIGN_EN
    .rdata_hi  (dmem.data_rdata),
    .be_hi     (be_hi),
    .wdata_hi  (wdata_hi),
`endif
    .be_lo     (be_lo),
    .wdata_lo  (wdata_lo),
    .rdata_fmt (rdata_fmt)
  );

  // bus fields are forced to zero whenever no request is presented
  always_comb begin
    bus_we    = 1'b0;
    bus_be    = 4'h0;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    if (req) begin
      bus_we    = we_q;
      bus_addr  = {addr_q[31:2], 2'b00};
      bus_be    = be_lo;
      bus_wdata = wdata_lo;
`ifdef RV_LSU_MISALIGN_EN
      if (state_q == REQ2) begin
        bus_addr  = {addr_q[31:2] + 30'd1, 2'b00};
        bus_be    = be_hi;
        bus_wdata = wdata_hi;
      end
`endif
    end
  end

  assign dmem.data_req   = req;
  assign dmem.data_we    = bus_we;
  assign dmem.data_addr  = bus_addr;
  assign dmem.data_be    = bus_be;
  assign dmem.data_wdata = bus_wdata;

  assign lsu_rvalid = rvalid_q;
  assign lsu_err    = err_q;
  assign lsu_rdata  = rdata_q;
  assign lsu_busy   = (state_q != IDLE);

endmodule
